// File: rtl/ts_monitor.sv
// Temperature-sensor monitor: 4-tap averaging filter, debounced hot/cold FSM
// with hysteresis, sticky interrupt flags and min/max tracking.
module ts_monitor #(
   parameter int DEB_W = 3
) (
   input  logic             clk,
   input  logic             RSTn,
   input  logic [3:0]       ts_code,
   input  logic             ts_tick,
   input  logic             reg_mon_en,
   input  logic [3:0]       reg_hi_th,
   input  logic [3:0]       reg_lo_th,
   input  logic [1:0]       reg_hyst,
   input  logic [DEB_W-1:0] reg_deb,
   input  logic             irq_clr,
   output logic [3:0]       ts_filt,
   output logic             ts_filt_vld,
   output logic [1:0]       ts_state,
   output logic             ts_hot,
   output logic             ts_cold,
   output logic             irq_hot,
   output logic             irq_cold,
   output logic [3:0]       ts_max,
   output logic [3:0]       ts_min
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FILL   = 3'd1,
      S_NORMAL = 3'd2,
      S_HOT    = 3'd3,
      S_COLD   = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       ent0, ent1, ent2, ent3;
   logic [2:0]       fill;
   logic [DEB_W-1:0] deb_cnt, deb_nxt;
   logic             deb_dir, dir_nxt;
   logic             set_hot, set_cold;

   logic             tick_ok;
   logic [5:0]       sum;
   logic [3:0]       filt_new;
   logic [DEB_W-1:0] deb_req, deb_inc, deb_one, hot_run, cold_run;
   logic [3:0]       hot_exit_th, cold_exit_th;
   logic [4:0]       cold_sum;
   logic             hot_q, cold_q;

   assign tick_ok  = ts_tick && reg_mon_en && (state != S_IDLE);
   assign sum      = {2'b00, ts_code} + {2'b00, ent0} + {2'b00, ent1} + {2'b00, ent2};
   assign filt_new = 4'(sum >> 2);

   assign deb_one  = DEB_W'(1);
   assign deb_req  = (reg_deb == '0) ? deb_one : reg_deb;
   assign deb_inc  = (deb_cnt == '1) ? deb_cnt : deb_cnt + deb_one;
   // deb_dir remembers which direction is being counted in NORMAL (1 = cold)
   assign hot_run  = deb_dir ? deb_one : deb_inc;
   assign cold_run = deb_dir ? deb_inc : deb_one;

   assign hot_exit_th  = (reg_hi_th > {2'b00, reg_hyst}) ? reg_hi_th - {2'b00, reg_hyst} : 4'd0;
   assign cold_sum     = {1'b0, reg_lo_th} + {3'b000, reg_hyst};
   assign cold_exit_th = cold_sum[4] ? 4'hF : cold_sum[3:0];

   assign hot_q  = (ts_filt >= reg_hi_th);
   assign cold_q = !hot_q && (ts_filt <= reg_lo_th);

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state   <= S_IDLE;
         deb_cnt <= '0;
         deb_dir <= 1'b0;
      end else begin
         state   <= state_nxt;
         deb_cnt <= deb_nxt;
         deb_dir <= dir_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      deb_nxt   = deb_cnt;
      dir_nxt   = deb_dir;
      set_hot   = 1'b0;
      set_cold  = 1'b0;
      if (!reg_mon_en) begin
         state_nxt = S_IDLE;
         deb_nxt   = '0;
         dir_nxt   = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state_nxt = S_FILL;
               deb_nxt   = '0;
               dir_nxt   = 1'b0;
            end
            S_FILL: begin
               if (tick_ok && fill >= 3'd3) state_nxt = S_NORMAL;
            end
            S_NORMAL: begin
               if (ts_filt_vld) begin
                  if (hot_q) begin
                     dir_nxt = 1'b0;
                     if (hot_run >= deb_req) begin
                        state_nxt = S_HOT;
                        deb_nxt   = '0;
                        set_hot   = 1'b1;
                     end else begin
                        deb_nxt = hot_run;
                     end
                  end else if (cold_q) begin
                     if (cold_run >= deb_req) begin
                        state_nxt = S_COLD;
                        deb_nxt   = '0;
                        dir_nxt   = 1'b0;
                        set_cold  = 1'b1;
                     end else begin
                        deb_nxt = cold_run;
                        dir_nxt = 1'b1;
                     end
                  end else begin
                     deb_nxt = '0;
                  end
               end
            end
            S_HOT: begin
               if (ts_filt_vld) begin
                  if (ts_filt < hot_exit_th) begin
                     if (deb_inc >= deb_req) begin
                        state_nxt = S_NORMAL;
                        deb_nxt   = '0;
                     end else begin
                        deb_nxt = deb_inc;
                     end
                  end else begin
                     deb_nxt = '0;
                  end
               end
            end
            S_COLD: begin
               if (ts_filt_vld) begin
                  if (ts_filt > cold_exit_th) begin
                     if (deb_inc >= deb_req) begin
                        state_nxt = S_NORMAL;
                        deb_nxt   = '0;
                     end else begin
                        deb_nxt = deb_inc;
                     end
                  end else begin
                     deb_nxt = '0;
                  end
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Filter, fill counter, extremes and sticky flags; entering FILL restarts the history
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         ent0        <= '0;
         ent1        <= '0;
         ent2        <= '0;
         ent3        <= '0;
         fill        <= '0;
         ts_filt     <= '0;
         ts_filt_vld <= 1'b0;
         ts_max      <= 4'd0;
         ts_min      <= 4'd15;
         irq_hot     <= 1'b0;
         irq_cold    <= 1'b0;
      end else begin
         ts_filt_vld <= 1'b0;
         irq_hot     <= set_hot  | (irq_hot  & ~irq_clr);
         irq_cold    <= set_cold | (irq_cold & ~irq_clr);
         if (!reg_mon_en) begin
            fill <= '0;
         end else if (state == S_IDLE) begin
            ent0   <= '0;
            ent1   <= '0;
            ent2   <= '0;
            ent3   <= '0;
            fill   <= '0;
            ts_max <= 4'd0;
            ts_min <= 4'd15;
         end else begin
            if (tick_ok) begin
               ent0        <= ts_code;
               ent1        <= ent0;
               ent2        <= ent1;
               ent3        <= ent2;
               ts_filt     <= filt_new;
               ts_filt_vld <= (fill >= 3'd3);
               if (fill != 3'd4) fill <= fill + 3'd1;
            end
            if (ts_filt_vld) begin
               if (ts_filt > ts_max) ts_max <= ts_filt;
               if (ts_filt < ts_min) ts_min <= ts_filt;
            end
         end
      end
   end

   assign ts_hot  = (state == S_HOT);
   assign ts_cold = (state == S_COLD);

   always_comb begin
      case (state)
         S_IDLE:  ts_state = 2'b00;
         S_FILL:  ts_state = 2'b01;
         default: ts_state = 2'b10;
      endcase
   end

endmodule

// File: tb/tb_ts_monitor.sv
// Directed bench for ts_monitor: a per-update vector table for fill/debounce/
// hysteresis, then hand sequences for priority, irq clearing, disable and reset.
module tb_ts_monitor;

   logic       clk = 1'b0;
   logic       RSTn;
   logic [3:0] ts_code;
   logic       ts_tick;
   logic       reg_mon_en;
   logic [3:0] reg_hi_th, reg_lo_th;
   logic [1:0] reg_hyst;
   logic [2:0] reg_deb;
   logic       irq_clr;
   logic [3:0] ts_filt, ts_max, ts_min;
   logic       ts_filt_vld, ts_hot, ts_cold, irq_hot, irq_cold;
   logic [1:0] ts_state;

   int checks = 0;
   int fails  = 0;

   ts_monitor #(.DEB_W(3)) dut (
      .clk(clk), .RSTn(RSTn), .ts_code(ts_code), .ts_tick(ts_tick),
      .reg_mon_en(reg_mon_en), .reg_hi_th(reg_hi_th), .reg_lo_th(reg_lo_th),
      .reg_hyst(reg_hyst), .reg_deb(reg_deb), .irq_clr(irq_clr),
      .ts_filt(ts_filt), .ts_filt_vld(ts_filt_vld), .ts_state(ts_state),
      .ts_hot(ts_hot), .ts_cold(ts_cold), .irq_hot(irq_hot), .irq_cold(irq_cold),
      .ts_max(ts_max), .ts_min(ts_min)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] code;
      logic       clr;
      logic       vld;
      logic [3:0] filt;
      logic [1:0] st;
      logic       hot, cold, ihot, icold;
   } vec_t;

   vec_t tbl[24];

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic tick, input logic [3:0] code, input logic clr);
      ts_tick = tick;
      ts_code = code;
      irq_clr = clr;
      @(posedge clk);
      #1;
      ts_tick = 1'b0;
      irq_clr = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " state"}, ts_state, 0);
      checkOutput({tag, " filt"}, ts_filt, 0);
      checkOutput({tag, " vld"}, ts_filt_vld, 0);
      checkOutput({tag, " hot"}, ts_hot, 0);
      checkOutput({tag, " cold"}, ts_cold, 0);
      checkOutput({tag, " irq_hot"}, irq_hot, 0);
      checkOutput({tag, " irq_cold"}, irq_cold, 0);
      checkOutput({tag, " max"}, ts_max, 0);
      checkOutput({tag, " min"}, ts_min, 15);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // code, clr, vld, filt, state, hot, cold, irq_hot, irq_cold
      tbl[0]  = '{4'd4,  1'b0, 1'b0, 4'd1,  2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{4'd8,  1'b0, 1'b0, 4'd3,  2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{4'd8,  1'b0, 1'b0, 4'd5,  2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{4'd12, 1'b0, 1'b1, 4'd8,  2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{4'd12, 1'b0, 1'b1, 4'd10, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{4'd12, 1'b0, 1'b1, 4'd11, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{4'd0,  1'b0, 1'b1, 4'd9,  2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{4'd12, 1'b0, 1'b1, 4'd9,  2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{4'd15, 1'b0, 1'b1, 4'd9,  2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{4'd15, 1'b0, 1'b1, 4'd10, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{4'd15, 1'b0, 1'b1, 4'd14, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{4'd15, 1'b0, 1'b1, 4'd15, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{4'd0,  1'b0, 1'b1, 4'd11, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{4'd2,  1'b0, 1'b1, 4'd8,  2'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{4'd2,  1'b0, 1'b1, 4'd4,  2'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{4'd2,  1'b0, 1'b1, 4'd1,  2'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[16] = '{4'd2,  1'b0, 1'b1, 4'd2,  2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[17] = '{4'd2,  1'b0, 1'b1, 4'd2,  2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[18] = '{4'd2,  1'b0, 1'b1, 4'd2,  2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[19] = '{4'd2,  1'b0, 1'b1, 4'd2,  2'd2, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[20] = '{4'd2,  1'b1, 1'b1, 4'd2,  2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[21] = '{4'd15, 1'b0, 1'b1, 4'd5,  2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[22] = '{4'd15, 1'b0, 1'b1, 4'd8,  2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[23] = '{4'd15, 1'b0, 1'b1, 4'd11, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};

      RSTn       = 1'b0;
      ts_code    = 4'd0;
      ts_tick    = 1'b0;
      irq_clr    = 1'b0;
      reg_mon_en = 1'b0;
      reg_hi_th  = 4'd10;
      reg_lo_th  = 4'd2;
      reg_hyst   = 2'd2;
      reg_deb    = 3'd3;
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      #4 RSTn = 1'b1;

      $display("[TB] fill, debounce, hysteresis and cold table");
      reg_mon_en = 1'b1;
      applyStimulus(1'b0, 4'd0, 1'b0);
      checkOutput("enter fill state", ts_state, 1);
      checkOutput("enter fill max", ts_max, 0);
      checkOutput("enter fill min", ts_min, 15);
      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'b1, tbl[i].code, 1'b0);
         checkOutput($sformatf("row%0d vld", i), ts_filt_vld, tbl[i].vld);
         checkOutput($sformatf("row%0d filt", i), ts_filt, tbl[i].filt);
         applyStimulus(1'b0, 4'd0, tbl[i].clr);
         checkOutput($sformatf("row%0d vld drop", i), ts_filt_vld, 0);
         checkOutput($sformatf("row%0d state", i), ts_state, tbl[i].st);
         checkOutput($sformatf("row%0d hot", i), ts_hot, tbl[i].hot);
         checkOutput($sformatf("row%0d cold", i), ts_cold, tbl[i].cold);
         checkOutput($sformatf("row%0d irq_hot", i), irq_hot, tbl[i].ihot);
         checkOutput($sformatf("row%0d irq_cold", i), irq_cold, tbl[i].icold);
      end
      checkOutput("table max", ts_max, 15);
      checkOutput("table min", ts_min, 1);

      $display("[TB] priority with overlapping thresholds and deb=0");
      reg_hi_th  = 4'd5;
      reg_lo_th  = 4'd6;
      reg_deb    = 3'd0;
      reg_mon_en = 1'b0;
      applyStimulus(1'b0, 4'd0, 1'b0);
      checkOutput("disable from normal state", ts_state, 0);
      checkOutput("disable filt held", ts_filt, 11);
      checkOutput("disable max held", ts_max, 15);
      checkOutput("disable min held", ts_min, 1);
      reg_mon_en = 1'b1;
      applyStimulus(1'b0, 4'd0, 1'b0);
      checkOutput("refill state", ts_state, 1);
      checkOutput("refill max", ts_max, 0);
      checkOutput("refill min", ts_min, 15);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'd5, 1'b0);
         checkOutput($sformatf("prio fill%0d vld", i), ts_filt_vld, 0);
      end
      applyStimulus(1'b1, 4'd5, 1'b0);
      checkOutput("prio vld", ts_filt_vld, 1);
      checkOutput("prio filt", ts_filt, 5);
      checkOutput("prio state normal", ts_state, 2);
      applyStimulus(1'b0, 4'd0, 1'b1);
      checkOutput("prio hot", ts_hot, 1);
      checkOutput("prio cold", ts_cold, 0);
      checkOutput("prio irq_hot set beats clr", irq_hot, 1);
      checkOutput("prio irq_cold", irq_cold, 0);
      checkOutput("prio max", ts_max, 5);
      checkOutput("prio min", ts_min, 5);

      $display("[TB] disable in HOT, re-enable, late irq_clr");
      reg_mon_en = 1'b0;
      applyStimulus(1'b1, 4'd9, 1'b0);
      checkOutput("hot disable state", ts_state, 0);
      checkOutput("hot disable ts_hot", ts_hot, 0);
      checkOutput("hot disable irq held", irq_hot, 1);
      checkOutput("hot disable filt held", ts_filt, 5);
      checkOutput("hot disable max", ts_max, 5);
      checkOutput("hot disable min", ts_min, 5);
      applyStimulus(1'b0, 4'd0, 1'b0);
      checkOutput("idle stays idle", ts_state, 0);
      reg_mon_en = 1'b1;
      applyStimulus(1'b0, 4'd0, 1'b0);
      checkOutput("reenable state", ts_state, 1);
      checkOutput("reenable max", ts_max, 0);
      checkOutput("reenable min", ts_min, 15);
      checkOutput("reenable irq held", irq_hot, 1);
      applyStimulus(1'b0, 4'd0, 1'b1);
      checkOutput("late clr irq_hot", irq_hot, 0);
      applyStimulus(1'b1, 4'd9, 1'b0);
      checkOutput("midfill filt1", ts_filt, 2);
      applyStimulus(1'b1, 4'd9, 1'b0);
      checkOutput("midfill filt2", ts_filt, 4);

      $display("[TB] asynchronous reset mid-fill");
      RSTn = 1'b0;
      #2;
      checkResetValues("async reset");
      #2 RSTn = 1'b1;
      applyStimulus(1'b0, 4'd0, 1'b0);
      checkOutput("post reset fill state", ts_state, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'd8, 1'b0);
         checkOutput($sformatf("post reset tick%0d vld", i), ts_filt_vld, 0);
         checkOutput($sformatf("post reset tick%0d filt", i), ts_filt, 2 * (i + 1));
      end
      applyStimulus(1'b1, 4'd8, 1'b0);
      checkOutput("post reset vld", ts_filt_vld, 1);
      checkOutput("post reset filt", ts_filt, 8);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
